regfile_wb_scoreboard: RTL and testbench

- Sits in front of the 32x32 register file, whose single write port is ignored for rd=x0.
- Tracks which architectural registers have an in-flight producer and stalls issue on RAW/WAW hazards.
- Arbitrates the single write port between the ALU and LSU writeback sources, with anti-starvation for the LSU.
- Drives the register file write port from flops.

---
 rtl/regfile_wb_scoreboard.sv | 139 +++++++++++++
 tb/tb_regfile_wb_scoreboard.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scoreboard.sv
// ============================================================================
// regfile_wb_scoreboard: busy-bit scoreboard plus ALU/LSU writeback arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wb_scoreboard #(
  parameter int NREGS        = 32,
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic             issue_use_rs1,
  input  logic             issue_use_rs2,
  input  logic [4:0]       issue_rd,
  input  logic             issue_wen,
  output logic             issue_ready,
  input  logic             alu_wb_valid,
  input  logic [4:0]       alu_wb_rd,
  input  logic [XLEN-1:0]  alu_wb_data,
  output logic             alu_wb_ready,
  input  logic             lsu_wb_valid,
  input  logic [4:0]       lsu_wb_rd,
  input  logic [XLEN-1:0]  lsu_wb_data,
  output logic             lsu_wb_ready,
  output logic             rf_w_enb,
  output logic [4:0]       rf_rd,
  output logic [XLEN-1:0]  rf_w_data,
  output logic [NREGS-1:0] busy_vec,
  output logic [31:0]      stall_cnt
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic {ALU_PRI = 1'b0, LSU_PRI = 1'b1} arb_state_t;

  arb_state_t       state_q, state_d;
  logic [3:0]       starve_q, starve_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [31:0]      stall_q, stall_d;
  logic             w_enb_q;
  logic [4:0]       w_rd_q;
  logic [XLEN-1:0]  w_data_q;

  logic            fire;
  logic            alu_acc;
  logic            lsu_acc;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  assign issue_ready = !((issue_use_rs1 && busy_q[issue_rs1]) ||
                         (issue_use_rs2 && busy_q[issue_rs2]) ||
                         (issue_wen     && busy_q[issue_rd]));
  assign fire = issue_valid && issue_ready;

  // The arbiter FSM only ever grants one source, so the accepts are exclusive.
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    alu_wb_ready = 1'b1;
    lsu_wb_ready = !alu_wb_valid;
    if (state_q == ALU_PRI) begin
      if (alu_wb_valid && lsu_wb_valid) begin
        starve_d = starve_q + 4'd1;
        if (starve_d >= C_STARVE_MAX) begin
          state_d = LSU_PRI;
        end
      end else begin
        starve_d = 4'd0;
      end
    end else begin
      lsu_wb_ready = 1'b1;
      alu_wb_ready = !lsu_wb_valid;
      state_d      = ALU_PRI;
      starve_d     = 4'd0;
    end
  end

  assign alu_acc = alu_wb_valid && alu_wb_ready;
  assign lsu_acc = lsu_wb_valid && lsu_wb_ready;
  assign wb_rd   = lsu_acc ? lsu_wb_rd   : alu_wb_rd;
  assign wb_data = lsu_acc ? lsu_wb_data : alu_wb_data;

  // Clear on commit is applied first so a (hazard-impossible) concurrent set wins.
  always_comb begin
    busy_d = busy_q;
    if (w_enb_q) begin
      busy_d[w_rd_q] = 1'b0;
    end
    if (fire && issue_wen && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    stall_d = stall_q;
    if (issue_valid && !issue_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ALU_PRI;
      starve_q <= 4'd0;
      busy_q   <= '0;
      stall_q  <= 32'd0;
      w_enb_q  <= 1'b0;
      w_rd_q   <= 5'd0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
      stall_q  <= stall_d;
      if (alu_acc || lsu_acc) begin
        w_enb_q  <= (wb_rd != 5'd0);
        w_rd_q   <= wb_rd;
        w_data_q <= wb_data;
      end else begin
        w_enb_q  <= 1'b0;
      end
    end
  end

  assign rf_w_enb  = w_enb_q;
  assign rf_rd     = w_rd_q;
  assign rf_w_data = w_data_q;
  assign busy_vec  = busy_q;
  assign stall_cnt = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scoreboard.sv
// ============================================================================
// tb_regfile_wb_scoreboard: directed self-checking bench for the scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_wen;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_ready;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        rf_w_enb;
  logic [4:0]  rf_rd;
  logic [31:0] rf_w_data;
  logic [31:0] busy_vec;
  logic [31:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_wb_scoreboard #(.NREGS(32), .XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_ready(issue_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ready(lsu_wb_ready),
    .rf_w_enb(rf_w_enb), .rf_rd(rf_rd), .rf_w_data(rf_w_data),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; issue_wen = 1'b0;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = 32'd0;
    lsu_wb_valid = 1'b0; lsu_wb_rd = 5'd0; lsu_wb_data = 32'd0;
    #2;
    issue_use_rs1 = 1'b1; issue_rs1 = 5'd5; issue_use_rs2 = 1'b1; issue_rs2 = 5'd9;
    issue_wen = 1'b1; issue_rd = 5'd31;
    #1;
    chk("reset_busy", busy_vec, 32'd0);
    chk("reset_wenb", {31'd0, rf_w_enb}, 32'd0);
    chk("reset_ready", {31'd0, issue_ready}, 32'd1);
    chk("reset_stall", stall_cnt, 32'd0);
    tick(); tick();
    rst = 1'b0;
    issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0;

    // RAW hazard resolved by an ALU writeback
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd5;
    #1 chk("raw_first_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    chk("raw_busy5", busy_vec, 32'h0000_0020);
    issue_wen = 1'b0; issue_use_rs1 = 1'b1; issue_rs1 = 5'd5;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEAD_BEEF;
    #1;
    chk("raw_stall_ready", {31'd0, issue_ready}, 32'd0);
    chk("raw_alu_ready", {31'd0, alu_wb_ready}, 32'd1);
    tick();
    chk("raw_wenb", {31'd0, rf_w_enb}, 32'd1);
    chk("raw_rd", {27'd0, rf_rd}, 32'd5);
    chk("raw_data", rf_w_data, 32'hDEAD_BEEF);
    alu_wb_valid = 1'b0;
    #1 chk("raw_still_stalled", {31'd0, issue_ready}, 32'd0);
    tick();
    chk("raw_busy_clear", busy_vec, 32'd0);
    chk("raw_wenb_drop", {31'd0, rf_w_enb}, 32'd0);
    chk("raw_ready_back", {31'd0, issue_ready}, 32'd1);
    chk("raw_stall_cnt", stall_cnt, 32'd2);
    issue_valid = 1'b0; issue_use_rs1 = 1'b0;

    // x0 destination never becomes busy and is never written
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd0;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h1234_5678;
    #1 chk("x0_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    chk("x0_busy", busy_vec, 32'd0);
    chk("x0_wenb", {31'd0, rf_w_enb}, 32'd0);
    issue_valid = 1'b0; issue_wen = 1'b0; alu_wb_valid = 1'b0;
    tick();

    // Continuous contention: ALU four grants, then one LSU grant
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd10; alu_wb_data = 32'hAAAA_0000;
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd11; lsu_wb_data = 32'hBBBB_1111;
    for (int i = 0; i < 10; i++) begin
      logic exp_l;
      exp_l = ((i % 5) == 4);
      #1;
      chk($sformatf("arb_alu_ready_%0d", i), {31'd0, alu_wb_ready}, {31'd0, !exp_l});
      chk($sformatf("arb_lsu_ready_%0d", i), {31'd0, lsu_wb_ready}, {31'd0, exp_l});
      tick();
      chk($sformatf("arb_rf_rd_%0d", i), {27'd0, rf_rd}, exp_l ? 32'd11 : 32'd10);
      chk($sformatf("arb_rf_data_%0d", i), rf_w_data, exp_l ? 32'hBBBB_1111 : 32'hAAAA_0000);
    end
    alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
    tick();

    // WAW hazard on x7 resolved by an LSU writeback
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd7;
    #1 chk("waw_first_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    chk("waw_busy7", busy_vec, 32'h0000_0080);
    chk("waw_stall_ready", {31'd0, issue_ready}, 32'd0);
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd7; lsu_wb_data = 32'h0000_0077;
    #1 chk("waw_lsu_ready", {31'd0, lsu_wb_ready}, 32'd1);
    tick();
    chk("waw_wenb", {31'd0, rf_w_enb}, 32'd1);
    chk("waw_rd", {27'd0, rf_rd}, 32'd7);
    chk("waw_data", rf_w_data, 32'h0000_0077);
    lsu_wb_valid = 1'b0;
    #1 chk("waw_still_stalled", {31'd0, issue_ready}, 32'd0);
    tick();
    chk("waw_busy_clear", busy_vec, 32'd0);
    chk("waw_ready_back", {31'd0, issue_ready}, 32'd1);
    tick();
    chk("waw_busy7_again", busy_vec, 32'h0000_0080);
    chk("waw_stall_cnt", stall_cnt, 32'd4);
    issue_valid = 1'b0; issue_wen = 1'b0;

    // Reset between accept and commit discards the write
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h3333_3333;
    tick();
    chk("rst_pending_wenb", {31'd0, rf_w_enb}, 32'd1);
    alu_wb_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_wenb", {31'd0, rf_w_enb}, 32'd0);
    chk("rst_async_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_async_data", rf_w_data, 32'd0);
    chk("rst_async_busy", busy_vec, 32'd0);
    chk("rst_async_stall", stall_cnt, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_after_wenb", {31'd0, rf_w_enb}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
